// File: rtl/playseq_auto_pkg.sv
// Shared constants, state encoding and helpers for the PlaySeq automatic player.
package playseq_auto_pkg;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = IDX_W + 1;
    localparam int GAP_W = 12;
    localparam int PR_W  = 8;

    localparam int PRESS_CYC_DEF   = 100;
    localparam int RELEASE_CYC_DEF = 100;
    localparam int GAP_CYC_DEF     = 1500;

    // Codes are visible on db_estado, so keep them stable.
    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        INICIA    = 4'd1,
        ESPERA    = 4'd2,
        PRESSIONA = 4'd3,
        SOLTA     = 4'd4,
        FIM       = 4'd5
    } estado_t;

    // True when exactly one LED is lit.
    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/playseq_jogador_auto_if.sv
// Game-facing LED/button bus. master = automatic player, slave = game.
interface playseq_jogador_auto_if;
    logic [3:0] leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic       jogar;
    logic [3:0] botoes;

    modport master (
        input  leds, pronto, ganhou, perdeu, timeout,
        output jogar, botoes
    );

    modport slave (
        output leds, pronto, ganhou, perdeu, timeout,
        input  jogar, botoes
    );
endinterface

// File: rtl/playseq_seq_buffer.sv
// 16x4 sequence store: synchronous append at the count position, combinational read.
module playseq_seq_buffer
    import playseq_auto_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       wr_data,
    input  logic             cnt_clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [3:0]       rd_data,
    output logic [CNT_W-1:0] count
);
    logic [3:0] mem [DEPTH];

    // Append at count; a full buffer ignores writes so the count never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (wr_en && (count < CNT_W'(DEPTH))) begin
            mem[count[IDX_W-1:0]] <= wr_data;
            count                 <= count + CNT_W'(1);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/playseq_jogador_auto.sv
// Automatic PlaySeq player: captures the LED preview, then replays it on the buttons.
module playseq_jogador_auto
    import playseq_auto_pkg::*;
#(
    parameter int PRESS_CYC   = PRESS_CYC_DEF,
    parameter int RELEASE_CYC = RELEASE_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   habilita,
    input  logic                   iniciar,
    input  logic [3:0]             botoes_manual,
    playseq_jogador_auto_if.master game,
    output logic                   ativo,
    output logic [CNT_W-1:0]       n_capturados,
    output logic                   overflow,
    output logic                   erro_led,
    output logic [3:0]             db_estado
);
    estado_t          estado, estado_prox;
    logic [3:0]       leds_prev, bot_auto, rd_data;
    logic [GAP_W-1:0] gap_cnt;
    logic [PR_W-1:0]  pr_cnt;
    logic [IDX_W-1:0] idx;
    logic             led_edge, resultado, jogar_w;
    logic             wr_en, cnt_clr, set_ovf, set_err;
    logic             gap_clr, gap_inc, pr_clr, pr_inc, idx_clr, idx_inc;
    logic             unused_pronto;

    // The game's pronto is implied by the result lines; nothing else needs it.
    assign unused_pronto = game.pronto;

    assign led_edge  = (leds_prev == 4'd0) && (game.leds != 4'd0);
    assign resultado = game.ganhou | game.perdeu | game.timeout;

    playseq_seq_buffer u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (game.leds),
        .cnt_clr (cnt_clr),
        .rd_idx  (idx),
        .rd_data (rd_data),
        .count   (n_capturados)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    // LED history for edge detection and the sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            leds_prev <= 4'd0;
            overflow  <= 1'b0;
            erro_led  <= 1'b0;
        end else begin
            leds_prev <= game.leds;
            if (set_ovf) overflow <= 1'b1;
            if (set_err) erro_led <= 1'b1;
        end
    end

    // Gap, press/release and replay-index counters; all saturate or clear explicitly.
    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt <= '0;
            pr_cnt  <= '0;
            idx     <= '0;
        end else begin
            if (gap_clr)                       gap_cnt <= '0;
            else if (gap_inc && gap_cnt != '1) gap_cnt <= gap_cnt + GAP_W'(1);
            if (pr_clr)                        pr_cnt  <= '0;
            else if (pr_inc && pr_cnt != '1)   pr_cnt  <= pr_cnt + PR_W'(1);
            if (idx_clr)                       idx     <= '0;
            else if (idx_inc && idx != '1)     idx     <= idx + IDX_W'(1);
        end
    end

    // Next-state and per-state controls; a game result overrides everything but OCIOSO.
    always_comb begin
        estado_prox = estado;
        jogar_w     = 1'b0;
        bot_auto    = 4'd0;
        wr_en       = 1'b0;
        cnt_clr     = 1'b0;
        set_ovf     = 1'b0;
        set_err     = 1'b0;
        gap_clr     = 1'b1;
        gap_inc     = 1'b0;
        pr_clr      = 1'b1;
        pr_inc      = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar && habilita) estado_prox = INICIA;
            end
            INICIA: begin
                jogar_w     = 1'b1;
                cnt_clr     = 1'b1;
                idx_clr     = 1'b1;
                estado_prox = ESPERA;
            end
            ESPERA: begin
                if (led_edge) begin
                    if (!one_hot4(game.leds))            set_err = 1'b1;
                    else if (n_capturados < CNT_W'(DEPTH)) wr_en = 1'b1;
                    else                                 set_ovf = 1'b1;
                end
                gap_clr = (game.leds != 4'd0);
                gap_inc = (game.leds == 4'd0) && (n_capturados != '0);
                if ((game.leds == 4'd0) && (gap_cnt == GAP_W'(GAP_CYC - 1))) begin
                    idx_clr     = 1'b1;
                    estado_prox = PRESSIONA;
                end
            end
            PRESSIONA: begin
                bot_auto = rd_data;
                pr_clr   = 1'b0;
                pr_inc   = 1'b1;
                if (pr_cnt == PR_W'(PRESS_CYC - 1)) begin
                    pr_clr      = 1'b1;
                    estado_prox = SOLTA;
                end
            end
            SOLTA: begin
                pr_clr = 1'b0;
                pr_inc = 1'b1;
                if (pr_cnt == PR_W'(RELEASE_CYC - 1)) begin
                    pr_clr = 1'b1;
                    // Last entry replayed: the game previews the whole sequence again.
                    if ({1'b0, idx} == n_capturados - CNT_W'(1)) begin
                        cnt_clr     = 1'b1;
                        estado_prox = ESPERA;
                    end else begin
                        idx_inc     = 1'b1;
                        estado_prox = PRESSIONA;
                    end
                end
            end
            FIM: begin
                // Waiting for iniciar low keeps a held start from relaunching a game.
                if (!iniciar) estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase

        if (resultado && (estado != OCIOSO)) begin
            estado_prox = FIM;
            bot_auto    = 4'd0;
            wr_en       = 1'b0;
            set_ovf     = 1'b0;
            set_err     = 1'b0;
            cnt_clr     = 1'b0;
            idx_inc     = 1'b0;
        end
    end

    assign game.jogar  = jogar_w;
    assign game.botoes = habilita ? bot_auto : botoes_manual;
    assign ativo       = (estado != OCIOSO) && (estado != FIM);
    assign db_estado   = estado;

endmodule

// File: doc/playseq_jogador_auto.md
Name: playseq_jogador_auto

Overview:
- Automatic player for the PlaySeq game; sits on the player side of the game's LED/button interface.
- Watches the game's `leds` during each preview, records the shown sequence in a 16-entry buffer, then replays it on `botoes` with fixed press/release timing.
- Repeats round by round until the game reports `ganhou`, `perdeu` or `timeout`.
- Used as a self-play harness on the board, and as a bench driver for `jogo_playseq`.

Parameters:
- PRESS_CYC, 100, cycles each button is held during replay (100 ms at the 1 kHz game clock).
- RELEASE_CYC, 100, cycles all buttons are released between presses.
- GAP_CYC, 1500, idle-LED cycles after the last capture that end the preview and start replay.
- DEPTH, 16, sequence buffer entries. Fixed at 16; 4-bit index.

Ports:
- clock  in  1  game clock (1 kHz divided clock).
- reset  in  1  synchronous, active-high.
- habilita  in  1  1 = auto mode; 0 = `botoes` passes `botoes_manual` through.
- iniciar  in  1  level; start a game when idle.
- leds  in  4  game LED output, one-hot when lit.
- pronto  in  1  game finished.
- ganhou  in  1  game result: won.
- perdeu  in  1  game result: lost.
- timeout  in  1  game result: timed out.
- botoes_manual  in  4  physical buttons.
- jogar  out  1  start pulse to the game.
- botoes  out  4  buttons to the game.
- ativo  out  1  auto player running (not OCIOSO/FIM).
- n_capturados  out  5  entries captured in the current round, 0..16.
- overflow  out  1  sticky; a capture arrived with the buffer full.
- erro_led  out  1  sticky; a multi-hot LED edge was seen.
- db_estado  out  4  state code.

Behaviour:
Reset values:
- Reset has priority over everything and is effective the same edge, including mid-replay.
- After reset: state OCIOSO; `jogar`=0; `botoes`=0 when `habilita`=1; `n_capturados`=0; `overflow`=0; `erro_led`=0; all counters 0.
- `leds_prev` resets to 0000.

Common rules:
- `leds_prev` is a 1-cycle registered copy of `leds`.
- An LED edge is `leds_prev`==0000 and `leds`!=0000.
- `habilita`=0 at any time: `botoes`=`botoes_manual` combinationally. The FSM still advances internally.
- `ganhou`, `perdeu` or `timeout` high in any state except OCIOSO → next state FIM, with `botoes`=0 the same cycle.

States and codes:
- OCIOSO (0)
  - `iniciar`=1 and `habilita`=1 → INICIA.
- INICIA (1)
  - `jogar`=1 for exactly this one cycle.
  - Clear `n_capturados` and the write pointer.
  - → ESPERA.
- ESPERA (2), capturing.
  - One-hot edge with `n_capturados`<16: write `leds` to buffer[`n_capturados`]; `n_capturados`+1 visible next cycle; gap counter reset.
  - One-hot edge with `n_capturados`=16: no write; set `overflow`.
  - Multi-hot edge: no write; set `erro_led`.
  - Gap counter increments while `leds`==0000 and `n_capturados`>0.
  - Gap counter resets whenever `leds`!=0000.
  - Gap counter = GAP_CYC-1 → PRESSIONA, read index=0.
- PRESSIONA (3)
  - `botoes`=buffer[index] for exactly PRESS_CYC cycles → SOLTA.
- SOLTA (4)
  - `botoes`=0 for exactly RELEASE_CYC cycles.
  - If index=`n_capturados`-1: clear `n_capturados`, → ESPERA (next round; the game re-previews the full sequence).
  - Else: index+1, → PRESSIONA.
- FIM (5)
  - `botoes`=0; hold.
  - `iniciar`=0 → OCIOSO, so a held `iniciar` cannot auto-restart.

Arithmetic and simultaneous events:
- All counters saturate or clear explicitly; none wraps.
- GAP counter is 12 bits; press/release counter is 8 bits.
- LED edge in the same cycle as a result input: the result input wins; no capture.
- `iniciar` is ignored outside OCIOSO.

Latency:
- LED edge to buffer write: 0 cycles (same edge).
- Last LED off to first press: GAP_CYC cycles.

Decomposition:
- Package `playseq_auto_pkg`: state encoding constants (codes above), DEPTH=16, index width 4, default timing constants.
- One natural sub-module: `playseq_seq_buffer`, a 16x4 register file with synchronous write and combinational read, plus the count register.
- FSM and counters stay in the top module.

Test Plan:
- Start handshake: reset, `habilita`=1, `iniciar`=1 → `jogar`=1 for exactly one cycle one edge later; `db_estado`=1 then 2.
- Single round: drive `leds` 0001,0,0100,0 with 10-cycle pulses and 0 for GAP_CYC → `n_capturados`=2; `botoes`=0001 for 100 cycles, 0 for 100, 0100 for 100, 0 for 100; state returns to ESPERA.
- Full and overflow: 17 one-hot edges → `n_capturados`=16, `overflow`=1, entry 15 unchanged; replay presses 16 buttons.
- Bad LED: `leds`=0011 edge → `erro_led`=1, `n_capturados` unchanged.
- Abort: `perdeu`=1 mid-PRESSIONA → `botoes`=0 same cycle, state FIM; release `iniciar` → OCIOSO.
- Manual/reset: `habilita`=0, `botoes_manual`=1000 → `botoes`=1000; `reset` during SOLTA → all outputs at reset values next edge.
